// File: rtl/vga_timing.sv
// VGA timing generator: free-running pixel/line counters with registered
// sync, blank and frame-start flags that line up with the counts shown.
//
// Ports:
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   en           count enable; low freezes all state and drops frame_start
//   hcount       current pixel column (0 .. H_TOTAL-1)
//   vcount       current line (0 .. V_TOTAL-1)
//   hsync/vsync  sync pulses, active high
//   hblnk/vblnk  blanking, active high
//   frame_start  one-cycle pulse when the counters step into (0,0)
module vga_timing #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] hcount,
    output logic        hsync,
    output logic        hblnk,
    output logic [10:0] vcount,
    output logic        vsync,
    output logic        vblnk,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SS   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SE   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SS   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SE   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] h_nxt;
    logic [10:0] v_nxt;
    logic        h_wrap;

    always_comb begin
        h_wrap = (hcount == H_LAST);
        h_nxt  = h_wrap ? 11'd0 : hcount + 11'd1;
        v_nxt  = vcount;
        if (h_wrap) begin
            v_nxt = (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
        end
    end

    // Flags are decoded from the next counter values so that, once
    // registered, they describe the position being presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= 1'b0;
            hblnk       <= 1'b0;
            vsync       <= 1'b0;
            vblnk       <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hblnk       <= (h_nxt >= H_VIS);
            hsync       <= (h_nxt >= H_SS) && (h_nxt < H_SE);
            vblnk       <= (v_nxt >= V_VIS);
            vsync       <= (v_nxt >= V_SS) && (v_nxt < V_SE);
            frame_start <= (h_nxt == 11'd0) && (v_nxt == 11'd0);
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing with reduced geometry so whole frames stay short.
// Reference model is a plain position counter with flags decoded from it.
module tb_vga_timing;

    localparam int HV = 16;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 6;
    localparam int VV = 12;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic        frame_start;

    vga_timing #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .hcount(hcount),
        .hsync(hsync),
        .hblnk(hblnk),
        .vcount(vcount),
        .vsync(vsync),
        .vblnk(vblnk),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int mh = 0;
    int mv = 0;
    bit mfs = 1'b0;
    int hs_cnt = 0;
    int hb_cnt = 0;
    int fs_cnt = 0;
    logic [24:0] sb[$];

    function automatic logic [24:0] dut_vec();
        return {hcount, vcount, hsync, hblnk, vsync, vblnk, frame_start};
    endfunction

    function automatic logic [24:0] model_vec();
        logic hs_e, hb_e, vs_e, vb_e;
        hb_e = (mh >= HV);
        hs_e = (mh >= HV + HF) && (mh < HV + HF + HS);
        vb_e = (mv >= VV);
        vs_e = (mv >= VV + VF) && (mv < VV + VF + VS);
        return {11'(mh), 11'(mv), hs_e, hb_e, vs_e, vb_e, mfs};
    endfunction

    task automatic chk(input string tag, input logic [24:0] got,
                       input logic [24:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mh  = 0;
        mv  = 0;
        mfs = 1'b0;
        sb.delete();
    endtask

    // One clock edge: model predicts, pushes, DUT result is popped
    // and compared shortly after the edge.
    task automatic step(input logic e);
        logic [24:0] exp;
        en = e;
        @(posedge clk);
        if (e) begin
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            mfs = (mh == 0) && (mv == 0);
        end else begin
            mfs = 1'b0;
        end
        sb.push_back(model_vec());
        #1;
        exp = sb.pop_front();
        chk("sb", dut_vec(), exp);
        if (hsync) hs_cnt++;
        if (hblnk) hb_cnt++;
        if (frame_start) fs_cnt++;
    endtask

    task automatic run_to(input int h, input int v);
        int guard;
        guard = 0;
        while (!(mh == h && mv == v) && guard < 2 * FRAME) begin
            step(1'b1);
            guard++;
        end
        chk("run_to_bound", 25'(guard < 2 * FRAME), 25'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", dut_vec(), 25'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // First enabled edge after release moves to (1,0), no pulse.
        step(1'b1);
        chk("first_h", 25'(hcount), 25'd1);
        chk("first_fs", 25'(frame_start), 25'd0);

        // Rest of line 0 and wrap to line 1.
        for (int i = 1; i < HT; i++) begin
            step(1'b1);
            if (mh == HV) chk("hblnk_rise", 25'(hblnk), 25'd1);
            if (mh == HV - 1) chk("hblnk_pre", 25'(hblnk), 25'd0);
            if (mh == HV + HF) chk("hsync_rise", 25'(hsync), 25'd1);
            if (mh == HV + HF + HS) chk("hsync_fall", 25'(hsync), 25'd0);
        end
        chk("line_wrap", {hcount, vcount, 3'b0}, {11'd0, 11'd1, 3'b0});

        // Complete frame 1; every state visited exactly once.
        for (int i = HT; i < FRAME; i++) step(1'b1);
        chk("frame_end_pos", {hcount, vcount, 3'b0}, 25'd0);
        chk("frame_fs", 25'(frame_start), 25'd1);
        chk("fs_count", 25'(fs_cnt), 25'd1);
        chk("hsync_count", 25'(hs_cnt), 25'(VT * HS));
        chk("hblnk_count", 25'(hb_cnt), 25'(VT * (HT - HV)));

        // Frame 2.
        for (int i = 0; i < FRAME; i++) step(1'b1);
        chk("fs_count2", 25'(fs_cnt), 25'd2);

        // Enable toggling: holds while low, never pulses while low.
        for (int i = 0; i < 2 * HT + 6; i++) begin
            step(i[0] ? 1'b0 : 1'b1);
            if (i[0]) chk("fs_when_off", 25'(frame_start), 25'd0);
        end

        // Async reset mid-frame, no clock edge in between.
        run_to(10, 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", dut_vec(), 25'd0);
        @(posedge clk);
        #1;
        chk("reset_hold", dut_vec(), 25'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b1);
        chk("restart_pos", {hcount, vcount, 3'b0}, {11'd1, 11'd0, 3'b0});
        chk("restart_fs", 25'(frame_start), 25'd0);

        // Frame corner.
        run_to(HT - 1, VT - 1);
        chk("corner_flags", dut_vec(),
            {11'(HT - 1), 11'(VT - 1), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        step(1'b1);
        chk("corner_wrap", dut_vec(), 25'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
